// File: rtl/matrix_operand_packer_pkg.sv
// ----------------------------------------------------------------------------
// matrix_operand_packer_pkg
// Shared definitions for the matrix operand packer:
//   - state_t           : packer FSM states (LOAD_A, LOAD_B, EMIT)
//   - ELEMS_PER_MATRIX  : elements per matrix for the default 4x4 build
//   - WORDS_PER_FRAME   : packed words emitted per frame for the default build
//   - elems_per_matrix(), words_per_frame() : the same quantities for any
//     MATRIX_WIDTH, used by parameterised modules.
// ----------------------------------------------------------------------------
package matrix_operand_packer_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam int MATRIX_WIDTH_DEFAULT = 4;
    localparam int ELEMS_PER_MATRIX     = MATRIX_WIDTH_DEFAULT * MATRIX_WIDTH_DEFAULT;
    localparam int WORDS_PER_FRAME      = ELEMS_PER_MATRIX / 2;

    function automatic int elems_per_matrix(input int mw);
        return mw * mw;
    endfunction

    // Each word carries a row pair of one column from both A and B.
    function automatic int words_per_frame(input int mw);
        return (mw * mw) / 2;
    endfunction

endpackage

// File: rtl/matrix_operand_packer_operand_buffer.sv
// ----------------------------------------------------------------------------
// operand_buffer
// MATRIX_WIDTH x MATRIX_WIDTH element store, row-major (address = r*MW + c).
// One write port and two combinational read ports that return a vertically
// adjacent pair of elements from one column: M[row][col] and M[row+1][col].
//
// Ports:
//   clk        : clock, writes on rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : row-major write address
//   i_wr_data  : element to write
//   i_rd_row   : upper row of the pair (even, < MATRIX_WIDTH-1)
//   i_rd_col   : column of the pair
//   o_rd_data0 : M[i_rd_row][i_rd_col]
//   o_rd_data1 : M[i_rd_row+1][i_rd_col]
// ----------------------------------------------------------------------------
module operand_buffer #(
    parameter  int WIDTH        = 8,
    parameter  int MATRIX_WIDTH = 4,
    localparam int DEPTH        = MATRIX_WIDTH * MATRIX_WIDTH,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_row,
    input  logic [AW-1:0]    i_rd_col,
    output logic [WIDTH-1:0] o_rd_data0,
    output logic [WIDTH-1:0] o_rd_data1
);

    localparam logic [AW-1:0] ROW_STRIDE = AW'(MATRIX_WIDTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_addr0;
    logic [AW-1:0]    w_addr1;

    // Contents are deliberately not reset: a new frame always overwrites
    // every location before it is read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_addr0    = i_rd_row * ROW_STRIDE + i_rd_col;
    assign w_addr1    = w_addr0 + ROW_STRIDE;
    assign o_rd_data0 = r_mem[w_addr0];
    assign o_rd_data1 = r_mem[w_addr1];

endmodule

// File: rtl/matrix_operand_packer.sv
// ----------------------------------------------------------------------------
// matrix_operand_packer
// Collects matrix A then matrix B (row-major element stream) and emits
// MW*MW/2 packed words {A[r][c], A[r+1][c], B[r][c], B[r+1][c]} ordered by
// column (outer) and even row r (inner), then pulses frame_done.
//
// Ports:
//   clk, reset  : clock; asynchronous active-high reset
//   in_data     : element stream            in_valid / in_ready handshake
//   wdata       : packed word (A[r][c] MSB) w_en / w_ready handshake
//   frame_done  : one-cycle pulse after the final word of a frame transfers
//
// Optional build macro MATRIX_PACKER_STATUS_EN adds:
//   busy        : high unless idle at the start of a frame (LOAD_A, count 0)
//   frame_count : 16-bit wrapping count of completed frames
// ----------------------------------------------------------------------------
module matrix_operand_packer
    import matrix_operand_packer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MATRIX_WIDTH = 4,
    parameter int NUM_ELEMENTS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
    output logic                          w_en,
    input  logic                          w_ready,
`ifdef MATRIX_PACKER_STATUS_EN
    output logic                          busy,
    output logic [15:0]                   frame_count,
`endif
    output logic                          frame_done
);

    localparam int ELEMS = elems_per_matrix(MATRIX_WIDTH);
    localparam int WORDS = words_per_frame(MATRIX_WIDTH);
    localparam int CW    = $clog2(ELEMS);

    localparam logic [CW-1:0] LAST_ELEM = CW'(ELEMS - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
    localparam logic [CW-1:0] HALF_MW   = CW'(MATRIX_WIDTH / 2);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_elem_cnt;
    logic [CW-1:0]    r_word_cnt;
    logic             r_frame_done;

    logic             w_elem_xfer;
    logic             w_word_xfer;
    logic             w_last_elem;
    logic             w_last_word;
    logic             w_a_wr;
    logic             w_b_wr;
    logic [CW-1:0]    w_rd_row;
    logic [CW-1:0]    w_rd_col;
    logic [WIDTH-1:0] w_a0;
    logic [WIDTH-1:0] w_a1;
    logic [WIDTH-1:0] w_b0;
    logic [WIDTH-1:0] w_b1;

    assign w_elem_xfer = in_valid && in_ready;
    assign w_word_xfer = w_en && w_ready;
    assign w_last_elem = (r_elem_cnt == LAST_ELEM);
    assign w_last_word = (r_word_cnt == LAST_WORD);
    assign w_a_wr      = w_elem_xfer && (r_state == LOAD_A);
    assign w_b_wr      = w_elem_xfer && (r_state == LOAD_B);

    // Word index -> (column, even row): column is the outer loop, so the
    // low part of the index walks row pairs within one column.
    assign w_rd_col = r_word_cnt / HALF_MW;
    assign w_rd_row = (r_word_cnt % HALF_MW) << 1;

    operand_buffer #(
        .WIDTH        (WIDTH),
        .MATRIX_WIDTH (MATRIX_WIDTH)
    ) u_buf_a (
        .clk        (clk),
        .i_wr_en    (w_a_wr),
        .i_wr_addr  (r_elem_cnt),
        .i_wr_data  (in_data),
        .i_rd_row   (w_rd_row),
        .i_rd_col   (w_rd_col),
        .o_rd_data0 (w_a0),
        .o_rd_data1 (w_a1)
    );

    operand_buffer #(
        .WIDTH        (WIDTH),
        .MATRIX_WIDTH (MATRIX_WIDTH)
    ) u_buf_b (
        .clk        (clk),
        .i_wr_en    (w_b_wr),
        .i_wr_addr  (r_elem_cnt),
        .i_wr_data  (in_data),
        .i_rd_row   (w_rd_row),
        .i_rd_col   (w_rd_col),
        .o_rd_data0 (w_b0),
        .o_rd_data1 (w_b1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // wdata is driven only in EMIT and is a pure function of the word
    // index, so it holds automatically while the multiplier stalls.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_en         = 1'b0;
        wdata        = '0;
        case (r_state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && w_last_elem) begin
                    w_state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && w_last_elem) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                w_en  = 1'b1;
                wdata = {w_a0, w_a1, w_b0, w_b1};
                if (w_ready && w_last_word) begin
                    w_state_next = LOAD_A;
                end
            end
            default: begin
                w_state_next = LOAD_A;
            end
        endcase
    end

    // The element counter is shared by A and B; it returns to zero after
    // the last element of each matrix so it never wraps mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_elem_cnt   <= '0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_word_xfer && w_last_word;
            if (w_a_wr || w_b_wr) begin
                r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
            end
            if (w_word_xfer) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
            end
        end
    end

    assign frame_done = r_frame_done;

`ifdef MATRIX_PACKER_STATUS_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_word_xfer && w_last_word) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign busy        = (r_state != LOAD_A) || (r_elem_cnt != '0);
`endif

endmodule

// File: doc/matrix_operand_packer.md
MATRIX_OPERAND_PACKER -- requirements
Module: matrix_operand_packer

Interface
REQ-001 Parameter: WIDTH, 8, bits per matrix element.
REQ-002 Parameter: MATRIX_WIDTH, 4, matrix dimension; even, >= 2.
REQ-003 Parameter: NUM_ELEMENTS, 4, elements per output word; fixed at 4.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: in_data  input  WIDTH  element stream.
REQ-007 Port: in_valid  input  1  in_data valid.
REQ-008 Port: in_ready  output  1  packer accepts an element.
REQ-009 Port: wdata  output  NUM_ELEMENTS*WIDTH  packed operand word to the downstream multiplier.
REQ-010 Port: w_en  output  1  wdata valid.
REQ-011 Port: w_ready  input  1  multiplier can accept a word.
REQ-012 Port: frame_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-013 Element transfer SHALL occur on a clk edge with in_valid && in_ready; word transfer SHALL occur on a clk edge with w_en && w_ready.
REQ-014 FSM states SHALL be LOAD_A, LOAD_B, EMIT; the state after reset is LOAD_A.
REQ-015 LOAD_A: in_ready=1; the k-th accepted element (k=0..MW*MW-1) SHALL be stored to A[k/MW][k%MW] (row-major); after element MW*MW-1 -> LOAD_B.
REQ-016 LOAD_B: same as LOAD_A into B; after the last element -> EMIT.
REQ-017 EMIT: in_ready=0, w_en=1; emit MW*MW/2 words in order c=0..MW-1 (outer), r=0,2,..,MW-2 (inner).
REQ-018 Word SHALL be {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}, A[r][c] in the MSBs.
REQ-019 wdata SHALL be held stable while w_en=1 && w_ready=0; the index advances only on transfer.
REQ-020 Outside EMIT, w_en=0 and wdata=0.
REQ-021 On the transfer of the final word: frame_done=1 for the next cycle only; state -> LOAD_A; counters cleared; the next frame overwrites the buffers.
REQ-022 Element and word counters SHALL be sized clog2(MW*MW) and SHALL never wrap within a frame.
REQ-023 in_valid during EMIT SHALL be ignored with no element loss; the source holds data because in_ready=0.
REQ-024 Latency: first w_en SHALL be asserted the cycle after the last B element is accepted.

Reset
REQ-025 Reset SHALL force, asynchronously: state=LOAD_A, counters=0, w_en=0, wdata=0, frame_done=0, in_ready=1 once reset is released.
REQ-026 Reset mid-frame SHALL discard the partial frame; buffer contents need not be cleared.

Configuration
REQ-027 With MATRIX_PACKER_STATUS_EN defined, extra outputs SHALL exist: busy (1 = not LOAD_A or A-count != 0) and frame_count (16-bit, +1 per frame_done, wraps 0xFFFF->0, reset 0).
REQ-028 Without MATRIX_PACKER_STATUS_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (LOAD_A, LOAD_B, EMIT) and constants WORDS_PER_FRAME=MW*MW/2 and ELEMS_PER_MATRIX=MW*MW.
REQ-030 One sub-module, operand_buffer (MW*MW x WIDTH register array, write port plus two column-pair read ports), SHALL be instantiated twice, for A and B.

Verification
REQ-031 Load A[r][c]=4r+c+1, B[r][c]=0x80+4r+c, w_ready=1 -> words 0x01058084, 0x090D888C, ..., last 0x0C108B8F; frame_done pulses once.
REQ-032 Same frame, w_ready low for 3 cycles at word 2 -> wdata held at word 2 value; 8 words total, none duplicated or lost.
REQ-033 in_valid toggling 1/0 each cycle during load -> identical word sequence to REQ-031.
REQ-034 Reset asserted after 10 A elements, then a full clean frame -> output matches REQ-031 exactly; w_en never rises before the 32nd element.
REQ-035 in_valid held high through EMIT -> in_ready=0 throughout EMIT; the next frame's first element is accepted in the cycle after frame_done.
REQ-036 With MATRIX_PACKER_STATUS_EN defined, 3 back-to-back frames -> frame_count=3; busy=0 after the final frame_done.
